wbu_cw_unpack: RTL and testbench



---
 rtl/wbu_cw_unpack_pkg.sv | 16 +
 rtl/wbu_cw_unpack.sv | 125 ++++++++++++
 tb/tb_wbu_cw_unpack.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_cw_unpack_pkg.sv
// Shared bus-bridge definitions for the outbound codeword path.
package wbu_cw_unpack_pkg;

  localparam int unsigned CW_WIDTH = 36;
  localparam int unsigned CHUNK_W  = 6;
  localparam int unsigned CNT_W    = 3;

  localparam logic [CHUNK_W-1:0] NL_BITS = '0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    NL
  } state_e;

endpackage

// File: rtl/wbu_cw_unpack.sv
// Pops codewords from the bridge FIFO and serialises them MSB-first into
// 6-bit chunks, optionally closing each burst with a newline token.
module wbu_cw_unpack
  import wbu_cw_unpack_pkg::*;
#(
  parameter int unsigned CW          = CW_WIDTH,
  parameter bit          OPT_NEWLINE = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fifo_empty_n,
  input  logic [CW-1:0]      i_fifo_data,
  output logic               o_fifo_rd,
  output logic               o_stb,
  output logic               o_nl,
  output logic [CHUNK_W-1:0] o_bits,
  input  logic               i_busy,
  output logic               o_active
);

  localparam int unsigned NCHUNK = CW / CHUNK_W;
  localparam int unsigned SR_W   = CW - CHUNK_W;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sreg_q, sreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               nl_owed_q, nl_owed_d;
  logic               stb_q, stb_d;
  logic               nl_q, nl_d;
  logic [CHUNK_W-1:0] bits_q, bits_d;

  logic xfer;
  logic last;
  logic rd;

  assign xfer = stb_q && !i_busy;
  assign last = (count_q == '0);

  // A pop is only allowed when the loaded chunk can be presented without
  // stalling, so i_busy also blocks the IDLE pop.
  always_comb begin
    rd = 1'b0;
    unique case (state_q)
      IDLE:    rd = i_fifo_empty_n && !i_busy;
      SEND:    rd = i_fifo_empty_n && xfer && last;
      default: rd = 1'b0;
    endcase
    if (i_reset) rd = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    count_d   = count_q;
    nl_owed_d = nl_owed_q;
    stb_d     = stb_q;
    nl_d      = nl_q;
    bits_d    = bits_q;

    if (rd) begin
      state_d   = SEND;
      stb_d     = 1'b1;
      nl_d      = 1'b0;
      bits_d    = i_fifo_data[CW-1 -: CHUNK_W];
      sreg_d    = i_fifo_data[SR_W-1:0];
      count_d   = CNT_W'(NCHUNK - 1);
      nl_owed_d = OPT_NEWLINE;
    end else begin
      unique case (state_q)
        SEND: begin
          if (xfer) begin
            if (!last) begin
              bits_d  = sreg_q[SR_W-1 -: CHUNK_W];
              sreg_d  = sreg_q << CHUNK_W;
              count_d = count_q - 1'b1;
            end else if (nl_owed_q) begin
              state_d = NL;
              nl_d    = 1'b1;
              bits_d  = NL_BITS;
            end else begin
              state_d = IDLE;
              stb_d   = 1'b0;
            end
          end
        end
        NL: begin
          if (xfer) begin
            state_d   = IDLE;
            stb_d     = 1'b0;
            nl_d      = 1'b0;
            nl_owed_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      count_q   <= '0;
      nl_owed_q <= 1'b0;
      stb_q     <= 1'b0;
      nl_q      <= 1'b0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      count_q   <= count_d;
      nl_owed_q <= nl_owed_d;
      stb_q     <= stb_d;
      nl_q      <= nl_d;
      bits_q    <= bits_d;
    end
  end

  assign o_fifo_rd = rd;
  assign o_stb     = stb_q;
  assign o_nl      = nl_q;
  assign o_bits    = bits_q;
  assign o_active  = stb_q || (count_q != '0);

endmodule

// File: tb/tb_wbu_cw_unpack.sv
// Scoreboard bench: two units (newline off / on) fed from modelled FIFOs.
module tb_wbu_cw_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        busy;
  logic        empty_n [2];
  logic [35:0] data    [2];
  logic        rd      [2];
  logic        stb     [2];
  logic        nl      [2];
  logic [5:0]  bits    [2];
  logic        act     [2];

  wbu_cw_unpack #(.CW(36), .OPT_NEWLINE(1'b0)) u_d0 (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty_n(empty_n[0]), .i_fifo_data(data[0]),
    .o_fifo_rd(rd[0]), .o_stb(stb[0]), .o_nl(nl[0]), .o_bits(bits[0]),
    .i_busy(busy), .o_active(act[0]));

  wbu_cw_unpack #(.CW(36), .OPT_NEWLINE(1'b1)) u_d1 (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty_n(empty_n[1]), .i_fifo_data(data[1]),
    .o_fifo_rd(rd[1]), .o_stb(stb[1]), .o_nl(nl[1]), .o_bits(bits[1]),
    .i_busy(busy), .o_active(act[1]));

  logic [6:0]  exp_q  [2][$];
  logic [35:0] fifo_q [2][$];

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_mode = 1;  // 0 random, 1 low, 2 high

  logic       rd_pend   [2];
  logic       hold_prev [2];
  logic       prev_stb  [2];
  logic       prev_nl   [2];
  logic [5:0] prev_bits [2];
  logic       rst_prev;
  int n_xfer [2];
  int n_rd   [2];
  int run    [2];
  int last_run [2];

  task automatic chk(input string name, input int d, input longint act_v, input longint exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act_v, exp_v);
    end
  endtask

  // Reference: a word is six MSB-first 6-bit slices; every unit-1 burst ends in one newline.
  task automatic push_word(input logic [35:0] w);
    logic [35:0] s;
    for (int d = 0; d < 2; d++) fifo_q[d].push_back(w);
    for (int k = 0; k < 6; k++) begin
      s = (w >> (30 - 6 * k)) & 36'h3F;
      for (int d = 0; d < 2; d++) exp_q[d].push_back({1'b0, s[5:0]});
    end
  endtask

  task automatic end_burst();
    exp_q[1].push_back({1'b1, 6'h00});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 3000 && !(act[0] == 1'b0 && act[1] == 1'b0 &&
                         fifo_q[0].size() == 0 && fifo_q[1].size() == 0)) begin
      tick();
      n++;
    end
    chk("wait_idle_budget", 0, longint'(n < 3000), 1);
    tick();
    tick();
  endtask

  task automatic wait_xfer(input int d, input int target);
    int n = 0;
    while (n < 500 && n_xfer[d] < target) begin
      tick();
      n++;
    end
    chk("wait_xfer_budget", d, longint'(n < 500), 1);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rd_pend[d] && fifo_q[d].size() != 0) void'(fifo_q[d].pop_front());

    case (busy_mode)
      0:       busy = ($urandom_range(0, 3) == 0);
      2:       busy = 1'b1;
      default: busy = 1'b0;
    endcase

    for (int d = 0; d < 2; d++) begin
      if (rst_prev) begin
        chk("reset_stb", d, longint'(stb[d]), 0);
        chk("reset_nl", d, longint'(nl[d]), 0);
        chk("reset_bits", d, longint'(bits[d]), 0);
        chk("reset_active", d, longint'(act[d]), 0);
      end else if (!rst) begin
        if (hold_prev[d]) begin
          chk("hold_stb", d, longint'(stb[d]), longint'(prev_stb[d]));
          chk("hold_token", d, longint'({nl[d], bits[d]}), longint'({prev_nl[d], prev_bits[d]}));
        end
        if (stb[d] && !busy) begin
          n_xfer[d]++;
          chk("token_expected", d, longint'(exp_q[d].size() != 0), 1);
          if (exp_q[d].size() != 0)
            chk("token", d, longint'({nl[d], bits[d]}), longint'(exp_q[d].pop_front()));
        end
        if (!stb[d]) chk("idle_active", d, longint'(act[d]), 0);
      end
      hold_prev[d] = stb[d] && busy && !rst;
      prev_stb[d]  = stb[d];
      prev_nl[d]   = nl[d];
      prev_bits[d] = bits[d];
      if (stb[d]) run[d]++;
      else if (run[d] != 0) begin
        last_run[d] = run[d];
        run[d] = 0;
      end
      empty_n[d] = (fifo_q[d].size() != 0);
      data[d]    = (fifo_q[d].size() != 0) ? fifo_q[d][0] : '0;
    end
    rst_prev = rst;

    #1;
    for (int d = 0; d < 2; d++) begin
      rd_pend[d] = rd[d];
      if (rd[d]) begin
        n_rd[d]++;
        chk("rd_legal", d, longint'({empty_n[d], busy, rst, stb[d] && nl[d]}), 64'h8);
      end
    end
  end

  initial begin
    int r0, r1, x1;
    logic [63:0] rv;
    rst = 1'b1;
    busy = 1'b0;
    rst_prev = 1'b0;
    for (int d = 0; d < 2; d++) begin
      empty_n[d] = 1'b0; data[d] = '0; rd_pend[d] = 1'b0; hold_prev[d] = 1'b0;
      prev_stb[d] = 1'b0; prev_nl[d] = 1'b0; prev_bits[d] = '0;
      n_xfer[d] = 0; n_rd[d] = 0; run[d] = 0; last_run[d] = 0;
    end

    // FIFO already non-empty while reset is held: no pop may occur.
    push_word(36'h123456789);
    end_burst();
    repeat (4) tick();
    rst = 1'b0;
    wait_idle();

    // Single word, no stalls.
    r0 = n_rd[0]; r1 = n_rd[1];
    push_word(36'h123456789);
    end_burst();
    wait_idle();
    chk("single_rd", 1, n_rd[1] - r1, 1);
    chk("single_rd", 0, n_rd[0] - r0, 1);
    chk("single_run", 1, last_run[1], 7);
    chk("single_run", 0, last_run[0], 6);

    // Two words back-to-back: no bubble, one trailing newline.
    r0 = n_rd[0]; r1 = n_rd[1];
    push_word(36'hA5A5A5A5A);
    push_word(36'h0F0F0F0F0);
    end_burst();
    wait_idle();
    chk("b2b_rd", 1, n_rd[1] - r1, 2);
    chk("b2b_run", 1, last_run[1], 13);
    chk("b2b_run", 0, last_run[0], 12);

    // Stall for 5 cycles while chunk 3 is presented.
    r1 = n_rd[1];
    x1 = n_xfer[1];
    push_word(36'hDEADBEEF1);
    end_burst();
    wait_xfer(1, x1 + 2);
    busy_mode = 2;
    repeat (5) tick();
    busy_mode = 1;
    wait_idle();
    chk("stall_rd", 1, n_rd[1] - r1, 1);

    // New word arrives while the newline is held by busy.
    push_word(36'h13579BDF0);
    end_burst();
    begin
      int n = 0;
      while (n < 200 && !(stb[1] && nl[1])) begin
        tick();
        n++;
      end
      chk("nl_seen", 1, longint'(n < 200), 1);
    end
    busy_mode = 2;
    tick();
    push_word(36'h2468ACE02);
    end_burst();
    repeat (4) tick();
    chk("nl_held", 1, longint'({stb[1], nl[1]}), 3);
    busy_mode = 1;
    wait_idle();

    // Reset after the second chunk of an all-ones word.
    x1 = n_xfer[1];
    push_word(36'hFFFFFFFFF);
    end_burst();
    wait_xfer(1, x1 + 2);
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      fifo_q[d].delete();
    end
    rst = 1'b0;
    tick();
    push_word(36'h000000000);
    end_burst();
    wait_idle();

    // Randomised bursts with random backpressure.
    for (int b = 0; b < 30; b++) begin
      busy_mode = ($urandom_range(0, 1) == 0) ? 0 : 1;
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        rv = {$urandom(), $urandom()};
        push_word(rv[35:0]);
      end
      end_burst();
      wait_idle();
    end
    busy_mode = 1;
    tick();

    for (int d = 0; d < 2; d++) chk("drained", d, exp_q[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
